// File: rtl/aes_256_para_ctrl_if.sv
// Batch handshake bundle between the CTR front-end, the round controller and the consumer.
// Latency: none; wires only.
// Backpressure: valid/ready on both the input batch and the output batch.
interface aes_256_para_ctrl_if #(
  parameter int BLOCK_SIZE = 128,
  parameter int LANES      = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [BLOCK_SIZE*LANES-1:0]   in_text;
  logic                          out_valid;
  logic                          out_ready;
  logic [BLOCK_SIZE*LANES-1:0]   out_text;

  // Producer of batches and consumer of results
  modport master (
    output in_valid, in_text, out_ready,
    input  in_ready, out_valid, out_text
  );

  // The round controller
  modport slave (
    input  in_valid, in_text, out_ready,
    output in_ready, out_valid, out_text
  );
endinterface

// File: rtl/aes_256_para_ctrl.sv
// Round sequencer and state holder for the 16-lane AES-256 combinational round datapath.
// Latency: batch accepted in cycle T is presented with out_valid in cycle T+15.
// Backpressure: one batch in flight; in_ready low until the result is taken by out_ready.
module aes_256_para_ctrl #(
  parameter int BLOCK_SIZE = 128,
  parameter int LANES      = 16,
  parameter int NR         = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  aes_256_para_ctrl_if.slave            bus,
  input  logic                          key_we,
  input  logic [3:0]                    key_addr,
  input  logic [BLOCK_SIZE-1:0]         key_wdata,
  output logic                          busy,
  output logic [BLOCK_SIZE*LANES-1:0]   dp_input_text,
  output logic [BLOCK_SIZE-1:0]         dp_round_key,
  output logic [3:0]                    dp_round,
  input  logic [BLOCK_SIZE*LANES-1:0]   dp_output_text
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                        state;
  logic [BLOCK_SIZE*LANES-1:0]   state_reg;
  logic [3:0]                    round_cnt;
  logic                          in_ready_q;
  logic                          out_valid_q;
  logic                          busy_q;

  // Round keys 0..NR; deliberately not reset so a reset does not force a key reload
  logic [BLOCK_SIZE-1:0]         key_ram [0:NR];

  // Key writes land only while idle; the accept cycle still reads the old key[0]
  always_ff @(posedge clk) begin
    if (key_we && (state == IDLE) && (key_addr <= LAST_ROUND)) begin
      key_ram[key_addr] <= key_wdata;
    end
  end

  // Batch FSM: whitening on accept, one datapath round per cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      state_reg   <= '0;
      round_cnt   <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg  <= bus.in_text ^ {LANES{key_ram[0]}};
            round_cnt  <= 4'd1;
            state      <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          state_reg <= dp_output_text;
          if (round_cnt == LAST_ROUND) begin
            // Clearing the counter here keeps dp_round at 0 outside ROUND
            round_cnt   <= 4'd0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          round_cnt   <= 4'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = state_reg;
  assign busy          = busy_q;
  assign dp_input_text = state_reg;
  assign dp_round      = round_cnt;
  assign dp_round_key  = key_ram[round_cnt];

endmodule
